// File: rtl/bcd_conv_if.sv
// Request/response/engine signal bundle for the shared BCD converter scheduler.
interface bcd_conv_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [ID_W-1:0]      resp_id;
   logic [9:0]           resp_decimal;
   logic                 resp_err;
   logic                 conv_start;
   logic [7:0]           conv_bin;
   logic                 conv_done;
   logic [9:0]           conv_decimal;

   modport slave (
      input  req_valid, req_data, resp_ready, conv_done, conv_decimal,
      output req_ready, resp_valid, resp_id, resp_decimal, resp_err, conv_start, conv_bin
   );

   modport master (
      output req_valid, req_data, resp_ready, conv_done, conv_decimal,
      input  req_ready, resp_valid, resp_id, resp_decimal, resp_err, conv_start, conv_bin
   );
endinterface

// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler sharing one sequential binary-to-BCD engine among NUM_REQ clients.
//
// state  | meaning
// IDLE   | arbitrate; grant first valid requester from rr_ptr
// LAUNCH | one-cycle conv_start pulse, timer cleared
// WAIT   | wait for conv_done or timer reaching TIMEOUT-1
// RESP   | hold response until resp_ready
module bcd_conv_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   bcd_conv_if.slave  bus
);
   localparam int TMR_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

   state_t             state, state_nx;
   logic [ID_W-1:0]    rr_ptr, rr_ptr_nx;
   logic [TMR_W-1:0]   timer, timer_nx;
   logic [7:0]         conv_bin_q, conv_bin_nx;
   logic [ID_W-1:0]    resp_id_q, resp_id_nx;
   logic [9:0]         resp_dec_q, resp_dec_nx;
   logic               resp_err_q, resp_err_nx;

   logic               grant_found;
   logic [ID_W-1:0]    grant_idx;
   logic [ID_W-1:0]    cand_idx;
   logic [NUM_REQ-1:0] grant_vec;
   int                 cand;

   // Rotating priority search starting at rr_ptr
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      cand_idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cand_idx = ID_W'(cand);
         if (!grant_found && bus.req_valid[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
      grant_vec = '0;
      if (grant_found && state == IDLE && rst_n) grant_vec[grant_idx] = 1'b1;
   end

   always_comb begin
      state_nx    = state;
      rr_ptr_nx   = rr_ptr;
      timer_nx    = timer;
      conv_bin_nx = conv_bin_q;
      resp_id_nx  = resp_id_q;
      resp_dec_nx = resp_dec_q;
      resp_err_nx = resp_err_q;
      case (state)
         IDLE: begin
            if (grant_found) begin
               conv_bin_nx = bus.req_data[8*int'(grant_idx) +: 8];
               resp_id_nx  = grant_idx;
               state_nx    = LAUNCH;
            end
         end
         LAUNCH: begin
            timer_nx = '0;
            state_nx = WAIT;
         end
         WAIT: begin
            // done is checked first so it wins a tie with the timeout
            if (bus.conv_done) begin
               resp_dec_nx = bus.conv_decimal;
               resp_err_nx = (bus.conv_decimal[3:0] > 4'd9) || (bus.conv_decimal[7:4] > 4'd9);
               state_nx    = RESP;
            end else if (timer == TMR_W'(TIMEOUT-1)) begin
               resp_dec_nx = '0;
               resp_err_nx = 1'b1;
               state_nx    = RESP;
            end else begin
               timer_nx = timer + TMR_W'(1);
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               rr_ptr_nx = (resp_id_q == ID_W'(NUM_REQ-1)) ? '0 : resp_id_q + ID_W'(1);
               state_nx  = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         timer      <= '0;
         conv_bin_q <= '0;
         resp_id_q  <= '0;
         resp_dec_q <= '0;
         resp_err_q <= 1'b0;
      end else begin
         state      <= state_nx;
         rr_ptr     <= rr_ptr_nx;
         timer      <= timer_nx;
         conv_bin_q <= conv_bin_nx;
         resp_id_q  <= resp_id_nx;
         resp_dec_q <= resp_dec_nx;
         resp_err_q <= resp_err_nx;
      end
   end

   assign bus.req_ready    = grant_vec;
   assign bus.conv_start   = (state == LAUNCH);
   assign bus.conv_bin     = conv_bin_q;
   assign bus.resp_valid   = (state == RESP);
   assign bus.resp_id      = resp_id_q;
   assign bus.resp_decimal = resp_dec_q;
   assign bus.resp_err     = resp_err_q;
endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Directed bench for bcd_conv_scheduler with a behavioural converter engine model.
module tb_bcd_conv_scheduler;
   logic clk;
   logic rst_n;
   int   n_chk  = 0;
   int   n_fail = 0;

   bcd_conv_if #(.NUM_REQ(4), .ID_W(2)) bus();

   bcd_conv_scheduler #(.NUM_REQ(4), .ID_W(2), .TIMEOUT(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Engine model: done during the k-th cycle after the start pulse
   logic       eng_en;
   logic       eng_bad;
   logic [9:0] eng_bad_val;
   int         eng_delay;
   logic       eng_busy = 1'b0;
   int         eng_cnt  = 0;
   logic [9:0] eng_val  = '0;

   function automatic logic [9:0] to_bcd(input logic [7:0] b);
      int v;
      v = int'(b);
      return {2'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   always @(posedge clk) begin
      if (bus.conv_start) begin
         eng_busy <= 1'b1;
         eng_cnt  <= eng_delay;
         eng_val  <= eng_bad ? eng_bad_val : to_bcd(bus.conv_bin);
      end else if (eng_busy && eng_cnt == 1) begin
         eng_busy <= 1'b0;
      end else if (eng_busy) begin
         eng_cnt <= eng_cnt - 1;
      end
   end

   assign bus.conv_done    = eng_en && eng_busy && (eng_cnt == 1);
   assign bus.conv_decimal = bus.conv_done ? eng_val : 10'h3FF;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // From LAUNCH, tick until resp_valid; n = ticks taken
   task automatic wait_resp(output int n);
      int starts;
      n = 0;
      starts = 0;
      while (!bus.resp_valid && n < 60) begin
         tick();
         n++;
         if (bus.conv_start) starts++;
      end
      chk("resp_seen", 32'(bus.resp_valid), 32'd1);
      chk("single_start", 32'(starts), 32'd0);
   endtask

   // Checks grant in IDLE, launch, latency and payload; ends in RESP
   task automatic txn(input int id, input logic [7:0] bin, input logic [9:0] dec,
                      input logic err, input int lat);
      int n;
      #1;
      chk("grant", 32'(bus.req_ready), 32'(1 << id));
      tick();
      chk("conv_start", 32'(bus.conv_start), 32'd1);
      chk("conv_bin", 32'(bus.conv_bin), 32'(bin));
      chk("ready_busy", 32'(bus.req_ready), 32'd0);
      wait_resp(n);
      chk("latency", 32'(n), 32'(lat));
      chk("resp_id", 32'(bus.resp_id), 32'(id));
      chk("resp_decimal", 32'(bus.resp_decimal), 32'(dec));
      chk("resp_err", 32'(bus.resp_err), 32'(err));
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.req_valid  = '0;
      bus.req_data   = '0;
      bus.resp_ready = 1'b1;
      eng_en         = 1'b1;
      eng_bad        = 1'b0;
      eng_bad_val    = '0;
      eng_delay      = 8;
      repeat (3) tick();
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
      chk("rst_resp_decimal", 32'(bus.resp_decimal), 32'd0);
      chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
      chk("rst_conv_start", 32'(bus.conv_start), 32'd0);
      chk("rst_conv_bin", 32'(bus.conv_bin), 32'd0);
      rst_n = 1'b1;

      // Single request, 8-cycle engine: response 10 cycles after grant
      bus.req_data  = {8'd0, 8'd0, 8'd0, 8'd255};
      bus.req_valid = 4'b0001;
      txn(0, 8'd255, 10'h255, 1'b0, 9);
      bus.req_valid = '0;
      tick();
      chk("accept_clears_valid", 32'(bus.resp_valid), 32'd0);

      // All four requesting: round-robin 0,1,2,3 then 0 again
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      eng_delay     = 2;
      bus.req_data  = {8'd199, 8'd100, 8'd9, 8'd0};
      bus.req_valid = 4'b1111;
      txn(0, 8'd0,   10'h000, 1'b0, 3); tick();
      txn(1, 8'd9,   10'h009, 1'b0, 3); tick();
      txn(2, 8'd100, 10'h100, 1'b0, 3); tick();
      txn(3, 8'd199, 10'h199, 1'b0, 3); tick();
      txn(0, 8'd0,   10'h000, 1'b0, 3);
      bus.req_valid = '0;
      tick();

      // Timeout: no done ever, error after 16 WAIT cycles
      eng_en        = 1'b0;
      bus.req_data  = {8'd0, 8'd37, 8'd42, 8'd0};
      bus.req_valid = 4'b0010;
      txn(1, 8'd42, 10'h000, 1'b1, 17);
      bus.req_valid = '0;
      tick();
      eng_en        = 1'b1;
      bus.req_valid = 4'b0110;
      txn(2, 8'd37, 10'h037, 1'b0, 3);
      bus.req_valid = '0;
      tick();

      // Invalid digits passed through with err
      eng_bad       = 1'b1;
      eng_bad_val   = 10'h0A5;
      bus.req_data  = {8'd165, 8'd0, 8'd0, 8'd90};
      bus.req_valid = 4'b1000;
      txn(3, 8'd165, 10'h0A5, 1'b1, 3);
      bus.req_valid = '0;
      tick();
      eng_bad_val   = 10'h05A;
      bus.req_valid = 4'b0001;
      txn(0, 8'd90, 10'h05A, 1'b1, 3);
      bus.req_valid = '0;
      tick();
      eng_bad       = 1'b0;

      // Done on the same cycle the timeout would fire: done wins
      eng_delay     = 16;
      bus.req_data  = {8'd0, 8'd7, 8'd254, 8'd0};
      bus.req_valid = 4'b0010;
      txn(1, 8'd254, 10'h254, 1'b0, 17);
      bus.req_valid = '0;
      tick();
      // Fastest engine: done in the first WAIT cycle
      eng_delay     = 1;
      bus.req_valid = 4'b0100;
      txn(2, 8'd7, 10'h007, 1'b0, 2);
      bus.req_valid = '0;
      tick();

      // Backpressure with requester 2 pending
      eng_delay      = 2;
      bus.resp_ready = 1'b0;
      bus.req_data   = {8'd77, 8'd5, 8'd0, 8'd0};
      bus.req_valid  = 4'b1000;
      txn(3, 8'd77, 10'h077, 1'b0, 3);
      bus.req_valid  = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_valid", 32'(bus.resp_valid), 32'd1);
         chk("bp_id", 32'(bus.resp_id), 32'd3);
         chk("bp_decimal", 32'(bus.resp_decimal), 32'h077);
         chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.resp_ready = 1'b1;
      #1;
      chk("accept_cycle_no_grant", 32'(bus.req_ready), 32'd0);
      tick();
      txn(2, 8'd5, 10'h005, 1'b0, 3);
      bus.req_valid = '0;
      tick();

      // Reset during WAIT; late done must be ignored
      eng_delay     = 8;
      bus.req_data  = {8'd200, 8'd0, 8'd0, 8'd128};
      bus.req_valid = 4'b1000;
      #1;
      chk("pre_rst_grant", 32'(bus.req_ready), 32'b1000);
      tick();
      bus.req_valid = '0;
      tick();
      tick();
      rst_n         = 1'b0;
      bus.req_valid = 4'b1001;
      tick();
      chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("midrst_conv_start", 32'(bus.conv_start), 32'd0);
      chk("midrst_conv_bin", 32'(bus.conv_bin), 32'd0);
      chk("midrst_resp_id", 32'(bus.resp_id), 32'd0);
      chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
      bus.req_valid = '0;
      rst_n         = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("late_done_valid", 32'(bus.resp_valid), 32'd0);
         chk("late_done_start", 32'(bus.conv_start), 32'd0);
      end
      bus.req_valid = 4'b1001;
      txn(0, 8'd128, 10'h128, 1'b0, 9);
      bus.req_valid = '0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
